vga_timing_generator: RTL and testbench

- Upstream pixel-timing stage of the graphics pipeline.
- Divides the system clock into a pixel tick and scans a 640x480@60 raster with horizontal/vertical counters.
- Drives x_pos_o/y_pos_o into every sprite/score controller. Takes back their merged RGB and emits aligned hsync/vsync/blank/RGB to the VGA DAC.
- Delays sync and blank to match the read latency of the controllers' sprite ROMs.

---
 rtl/vga_timing_generator.sv | 150 +++++++++++++++
 tb/tb_vga_timing_generator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: pixel-tick divider, h/v scan counters and a
// tick-aligned delay line that lines sync/blank up with the controllers' RGB.
module vga_timing_generator #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_i,
  output logic [31:0] x_pos_o,
  output logic [31:0] y_pos_o,
  output logic        pixel_tick_o,
  output logic        vga_clk_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_n_o,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        vblank_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int PD      = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;

  localparam logic [31:0] H_VIS_32   = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS_32   = 32'(V_VISIBLE);
  localparam logic [31:0] HS_START   = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END     = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START   = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END     = 32'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [2:0]  CTRL_IDLE  = 3'b011;  // {active, hs, vs} while blanked

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          tick_s;
  logic          h_end_s;
  logic          v_end_s;
  logic [31:0]   h_ext_s;
  logic [31:0]   v_ext_s;
  logic [31:0]   v_next_ext_s;
  logic [2:0]    raw_s;
  logic [2:0]    del_s;
  logic [2:0]    pipe_q [PD];
  logic          vga_clk_q;
  logic          vblank_q;
  logic          frame_start_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          blank_n_q;
  logic [23:0]   rgb_q;

  assign tick_s       = (div_q == DW'(CLK_DIV - 1));
  assign h_end_s      = (h_q == HW'(H_TOTAL - 1));
  assign v_end_s      = (v_q == VW'(V_TOTAL - 1));
  assign h_ext_s      = 32'(h_q);
  assign v_ext_s      = 32'(v_q);
  assign v_next_ext_s = 32'(v_d);

  // Raw controls for the coordinate currently on x/y_pos_o.
  assign raw_s[2] = (h_ext_s < H_VIS_32) && (v_ext_s < V_VIS_32);
  assign raw_s[1] = !((h_ext_s >= HS_START) && (h_ext_s < HS_END));
  assign raw_s[0] = !((v_ext_s >= VS_START) && (v_ext_s < VS_END));
  assign del_s    = (PIPE_DELAY == 0) ? raw_s : pipe_q[PD-1];

  // Next-state for the divider and the scan counters.
  always_comb begin
    div_d = tick_s ? {DW{1'b0}} : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick_s) begin
      if (h_end_s) begin
        h_d = {HW{1'b0}};
        if (v_end_s) begin
          v_d = {VW{1'b0}};
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      h_d = h_q;
    end
  end

  // State, alignment delay line and registered DAC outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= {DW{1'b0}};
      h_q           <= {HW{1'b0}};
      v_q           <= {VW{1'b0}};
      vga_clk_q     <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= 24'h000000;
      for (int i = 0; i < PD; i++) begin
        pipe_q[i] <= CTRL_IDLE;
      end
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      vga_clk_q     <= (div_d >= DW'(CLK_DIV / 2));
      vblank_q      <= (v_next_ext_s >= V_VIS_32);
      frame_start_q <= tick_s && h_end_s && v_end_s;
      if (tick_s) begin
        pipe_q[0] <= raw_s;
        for (int i = 1; i < PD; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
        blank_n_q <= del_s[2];
        hsync_q   <= del_s[1];
        vsync_q   <= del_s[0];
        rgb_q     <= del_s[2] ? rgb_i : 24'h000000;
      end
    end
  end

  assign x_pos_o       = h_ext_s;
  assign y_pos_o       = v_ext_s;
  assign pixel_tick_o  = tick_s;
  assign vga_clk_o     = vga_clk_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_n_o     = blank_n_q;
  assign r_o           = rgb_q[23:16];
  assign g_o           = rgb_q[15:8];
  assign b_o           = rgb_q[7:0];
  assign vblank_o      = vblank_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: one full-size instance and one reduced-raster instance,
// with expected samples queued by cycle and checked by a separate monitor.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst_s_n;
  logic [23:0] rgb_m;
  logic [23:0] rgb_white;

  logic [31:0] d_x, d_y;
  logic        d_tick, d_vclk, d_hs, d_vs, d_bn, d_vb, d_fs;
  logic [7:0]  d_r, d_g, d_b;
  logic [31:0] s_x, s_y;
  logic        s_tick, s_vclk, s_hs, s_vs, s_bn, s_vb, s_fs;
  logic [7:0]  s_r, s_g, s_b;

  vga_timing_generator dut (
    .clk(clk), .rst_n(rst_n), .rgb_i(rgb_m),
    .x_pos_o(d_x), .y_pos_o(d_y), .pixel_tick_o(d_tick), .vga_clk_o(d_vclk),
    .hsync_o(d_hs), .vsync_o(d_vs), .blank_n_o(d_bn),
    .r_o(d_r), .g_o(d_g), .b_o(d_b), .vblank_o(d_vb), .frame_start_o(d_fs)
  );

  vga_timing_generator #(
    .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .PIPE_DELAY(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .rgb_i(rgb_white),
    .x_pos_o(s_x), .y_pos_o(s_y), .pixel_tick_o(s_tick), .vga_clk_o(s_vclk),
    .hsync_o(s_hs), .vsync_o(s_vs), .blank_n_o(s_bn),
    .r_o(s_r), .g_o(s_g), .b_o(s_b), .vblank_o(s_vb), .frame_start_o(s_fs)
  );

  localparam int D_X = 0,  D_Y = 1,  D_TICK = 2, D_VCLK = 3, D_HS = 4, D_VS = 5;
  localparam int D_BN = 6, D_RGB = 7, D_VB = 8,  D_FS = 9,   D_HSW = 10;
  localparam int S = 16;
  localparam int S_VSW = 32, S_WHITE = 33, S_GATE = 34, S_FSGAP = 35, S_FSCNT = 36;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  int   b, r;

  int hs_low = 0, vs_low_s = 0, white_s = 0, gate_err_s = 0;
  int fs_last_s = 0, fs_gap_s = 0, fs_cnt_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: colour of the coordinate seen on this tick, one tick late.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_m <= 24'h000000;
    else if (d_tick) rgb_m <= {d_x[7:0], d_y[7:0], 8'hA5};
  end

  // Running measurements over the observed outputs.
  always @(negedge clk) begin
    if (!d_hs) hs_low <= hs_low + 1;
    if (!s_vs) vs_low_s <= vs_low_s + 1;
    if ({s_r, s_g, s_b} == 24'hFFFFFF) white_s <= white_s + 1;
    if (!s_bn && ({s_r, s_g, s_b} != 24'h000000)) gate_err_s <= gate_err_s + 1;
    if (s_fs) begin
      fs_gap_s  <= cyc - fs_last_s;
      fs_last_s <= cyc;
      fs_cnt_s  <= fs_cnt_s + 1;
    end
  end

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      D_X:       sample = d_x;
      D_Y:       sample = d_y;
      D_TICK:    sample = 32'(d_tick);
      D_VCLK:    sample = 32'(d_vclk);
      D_HS:      sample = 32'(d_hs);
      D_VS:      sample = 32'(d_vs);
      D_BN:      sample = 32'(d_bn);
      D_RGB:     sample = 32'({d_r, d_g, d_b});
      D_VB:      sample = 32'(d_vb);
      D_FS:      sample = 32'(d_fs);
      D_HSW:     sample = 32'(hs_low);
      S+D_X:     sample = s_x;
      S+D_Y:     sample = s_y;
      S+D_TICK:  sample = 32'(s_tick);
      S+D_VCLK:  sample = 32'(s_vclk);
      S+D_HS:    sample = 32'(s_hs);
      S+D_VS:    sample = 32'(s_vs);
      S+D_BN:    sample = 32'(s_bn);
      S+D_RGB:   sample = 32'({s_r, s_g, s_b});
      S+D_VB:    sample = 32'(s_vb);
      S+D_FS:    sample = 32'(s_fs);
      S_VSW:     sample = 32'(vs_low_s);
      S_WHITE:   sample = 32'(white_s);
      S_GATE:    sample = 32'(gate_err_s);
      S_FSGAP:   sample = 32'(fs_gap_s);
      S_FSCNT:   sample = 32'(fs_cnt_s);
      default:   sample = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int c, input int sel, input logic [31:0] e, input string nm);
    chk_t t;
    t.cyc = c; t.sel = sel; t.exp = e; t.name = nm;
    sb.push_back(t);
  endtask

  task automatic push_rst(input int c, input int off, input string tag);
    push(c, off+D_X,    32'd0, {tag, "_x"});
    push(c, off+D_Y,    32'd0, {tag, "_y"});
    push(c, off+D_TICK, 32'd0, {tag, "_tick"});
    push(c, off+D_VCLK, 32'd0, {tag, "_vclk"});
    push(c, off+D_HS,   32'd1, {tag, "_hsync"});
    push(c, off+D_VS,   32'd1, {tag, "_vsync"});
    push(c, off+D_BN,   32'd0, {tag, "_blank_n"});
    push(c, off+D_RGB,  32'd0, {tag, "_rgb"});
    push(c, off+D_VB,   32'd0, {tag, "_vblank"});
    push(c, off+D_FS,   32'd0, {tag, "_fs"});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation on its cycle, flag stale ones.
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          got = sample(sb[i].sel);
          n_tests = n_tests + 1;
          if (sb[i].cyc < cyc) begin
            n_fail = n_fail + 1;
            $display("FAIL %s not sampled at cyc=%0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
          end else if (got !== sb[i].exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", sb[i].name, cyc, got, sb[i].exp);
          end
          sb.delete(i);
        end
      end
      if (done) begin
        foreach (sb[i]) begin
          n_tests = n_tests + 1;
          n_fail  = n_fail + 1;
          $display("FAIL %s never checked (cyc=%0d)", sb[i].name, sb[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  // Stimulus: resets plus hand-computed expectations, cycle n after release.
  initial begin
    rst_n     = 1'b0;
    rst_s_n   = 1'b0;
    rgb_white = 24'hFFFFFF;
    push_rst(2, 0, "d_init");
    push_rst(2, S, "s_init");

    // Full-size raster: outputs after n edges show pixel floor(n/2)-2.
    wait_cyc(4);
    rst_n = 1'b1;
    b = cyc;
    push(b+0,    D_TICK, 32'd0,      "d_tick_n0");
    push(b+1,    D_TICK, 32'd1,      "d_first_tick");
    push(b+1,    D_VCLK, 32'd1,      "d_vclk_high");
    push(b+1,    D_X,    32'd0,      "d_x_before_tick");
    push(b+2,    D_X,    32'd1,      "d_x_after_tick");
    push(b+2,    D_VCLK, 32'd0,      "d_vclk_low");
    push(b+1315, D_HS,   32'd1,      "d_hs_before");
    push(b+1316, D_HS,   32'd0,      "d_hs_start");
    push(b+1507, D_HS,   32'd0,      "d_hs_last");
    push(b+1508, D_HS,   32'd1,      "d_hs_end");
    push(b+1599, D_X,    32'd799,    "d_x_799");
    push(b+1599, D_Y,    32'd0,      "d_y_line0");
    push(b+1600, D_X,    32'd0,      "d_x_wrap");
    push(b+1600, D_Y,    32'd1,      "d_y_line1");
    push(b+1600, D_HSW,  32'd192,    "d_hsync_width");
    push(b+8003, D_BN,   32'd0,      "d_l5_pre_blank");
    push(b+8003, D_RGB,  32'd0,      "d_l5_pre_rgb");
    push(b+8004, D_BN,   32'd1,      "d_l5_blank_n");
    push(b+8004, D_RGB,  32'h0005A5, "d_l5_px0_rgb");
    push(b+8004, D_VS,   32'd1,      "d_l5_vsync");
    push(b+8004, D_VB,   32'd0,      "d_l5_vblank");
    push(b+8006, D_RGB,  32'h0105A5, "d_l5_px1_rgb");
    push(b+8599, D_X,    32'd299,    "d_pre_rst_x");
    push(b+8599, D_Y,    32'd5,      "d_pre_rst_y");
    wait_cyc(b+8600);
    rst_n = 1'b0;
    r = cyc;
    push_rst(r+0, 0, "d_mid0");
    push_rst(r+1, 0, "d_mid1");
    push_rst(r+2, 0, "d_mid2");
    wait_cyc(r+3);
    rst_n = 1'b1;
    b = cyc;
    push(b+0, D_X,   32'd0,      "d_rs_x");
    push(b+0, D_FS,  32'd0,      "d_rs_fs");
    push(b+1, D_TICK,32'd1,      "d_rs_tick");
    push(b+2, D_X,   32'd1,      "d_rs_x1");
    push(b+2, D_BN,  32'd0,      "d_rs_flushed_bn");
    push(b+2, D_RGB, 32'd0,      "d_rs_flushed_rgb");
    push(b+2, D_FS,  32'd0,      "d_rs_fs2");
    push(b+3, D_BN,  32'd0,      "d_rs_bn3");
    push(b+4, D_BN,  32'd1,      "d_rs_bn4");
    push(b+4, D_RGB, 32'h0000A5, "d_rs_rgb00");
    wait_cyc(b+10);

    // Reduced raster 20x10, no delay: outputs show pixel floor(n/2)-1.
    rst_s_n = 1'b1;
    b = cyc;
    push(b+0,   S+D_FS,  32'd0,      "s_fs_n0");
    push(b+0,   S+D_VB,  32'd0,      "s_vb_n0");
    push(b+1,   S+D_TICK,32'd1,      "s_first_tick");
    push(b+1,   S+D_BN,  32'd0,      "s_bn_n1");
    push(b+1,   S+D_RGB, 32'd0,      "s_rgb_n1");
    push(b+2,   S+D_X,   32'd1,      "s_x1");
    push(b+2,   S+D_BN,  32'd1,      "s_bn_px0");
    push(b+2,   S+D_RGB, 32'hFFFFFF, "s_rgb_px0");
    push(b+29,  S+D_HS,  32'd1,      "s_hs_before");
    push(b+30,  S+D_HS,  32'd0,      "s_hs_start");
    push(b+30,  S+D_RGB, 32'd0,      "s_rgb_hblank");
    push(b+30,  S+D_BN,  32'd0,      "s_bn_hblank");
    push(b+37,  S+D_HS,  32'd0,      "s_hs_last");
    push(b+38,  S+D_HS,  32'd1,      "s_hs_end");
    push(b+39,  S+D_X,   32'd19,     "s_x19");
    push(b+40,  S+D_X,   32'd0,      "s_x_wrap");
    push(b+40,  S+D_Y,   32'd1,      "s_y1");
    push(b+42,  S_WHITE, 32'd24,     "s_white_line0");
    push(b+50,  S+D_RGB, 32'hFFFFFF, "s_rgb_l1");
    push(b+239, S+D_VB,  32'd0,      "s_vb_y5");
    push(b+240, S+D_VB,  32'd1,      "s_vb_rise");
    push(b+240, S+D_Y,   32'd6,      "s_y6");
    push(b+281, S+D_VS,  32'd1,      "s_vs_before");
    push(b+282, S+D_VS,  32'd0,      "s_vs_start");
    push(b+300, S+D_RGB, 32'd0,      "s_rgb_vblank");
    push(b+300, S+D_BN,  32'd0,      "s_bn_vblank");
    push(b+361, S+D_VS,  32'd0,      "s_vs_last");
    push(b+362, S+D_VS,  32'd1,      "s_vs_end");
    push(b+399, S+D_X,   32'd19,     "s_last_x");
    push(b+399, S+D_Y,   32'd9,      "s_last_y");
    push(b+399, S+D_VB,  32'd1,      "s_vb_last");
    push(b+399, S+D_FS,  32'd0,      "s_fs_pre");
    push(b+400, S+D_X,   32'd0,      "s_wrap_x");
    push(b+400, S+D_Y,   32'd0,      "s_wrap_y");
    push(b+400, S+D_VB,  32'd0,      "s_vb_fall");
    push(b+400, S+D_FS,  32'd1,      "s_fs_pulse1");
    push(b+400, S_VSW,   32'd80,     "s_vsync_width");
    push(b+400, S_WHITE, 32'd144,    "s_white_frame");
    push(b+401, S+D_FS,  32'd0,      "s_fs_one_clk");
    push(b+639, S+D_VB,  32'd0,      "s_vb2_pre");
    push(b+640, S+D_VB,  32'd1,      "s_vb2_rise");
    push(b+799, S+D_VB,  32'd1,      "s_vb2_last");
    push(b+800, S+D_VB,  32'd0,      "s_vb2_fall");
    push(b+800, S+D_FS,  32'd1,      "s_fs_pulse2");
    push(b+801, S_FSGAP, 32'd400,    "s_fs_period");
    push(b+801, S_FSCNT, 32'd2,      "s_fs_count");
    push(b+801, S_GATE,  32'd0,      "s_gate_errors");
    push(b+869, S+D_X,   32'd14,     "s_pre_rst_x");
    push(b+869, S+D_Y,   32'd1,      "s_pre_rst_y");
    wait_cyc(b+870);
    rst_s_n = 1'b0;
    r = cyc;
    push_rst(r+0, S, "s_mid0");
    push_rst(r+1, S, "s_mid1");
    push_rst(r+2, S, "s_mid2");
    wait_cyc(r+3);
    rst_s_n = 1'b1;
    b = cyc;
    push(b+0,  S+D_X,   32'd0,      "s_rs_x");
    push(b+0,  S+D_FS,  32'd0,      "s_rs_fs");
    push(b+1,  S+D_TICK,32'd1,      "s_rs_tick");
    push(b+2,  S+D_X,   32'd1,      "s_rs_x1");
    push(b+2,  S+D_RGB, 32'hFFFFFF, "s_rs_rgb");
    push(b+39, S+D_X,   32'd19,     "s_rs_x19");
    push(b+40, S+D_X,   32'd0,      "s_rs_wrap_x");
    push(b+40, S+D_Y,   32'd1,      "s_rs_wrap_y");
    push(b+45, S_FSCNT, 32'd2,      "s_rs_no_fs");
    wait_cyc(b+50);
    done = 1'b1;
  end

endmodule
